// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU commands,
// branch types, FSM states and instruction classes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b000101;
  localparam logic [5:0] OP_OR   = 6'b000110;
  localparam logic [5:0] OP_NOR  = 6'b000111;
  localparam logic [5:0] OP_XOR  = 6'b001000;
  localparam logic [5:0] OP_SLA  = 6'b001001;
  localparam logic [5:0] OP_SLL  = 6'b001010;
  localparam logic [5:0] OP_SRA  = 6'b001011;
  localparam logic [5:0] OP_SRL  = 6'b001100;
  localparam logic [5:0] OP_ADDI = 6'b100000;
  localparam logic [5:0] OP_SUBI = 6'b100001;
  localparam logic [5:0] OP_LD   = 6'b100100;
  localparam logic [5:0] OP_ST   = 6'b100101;
  localparam logic [5:0] OP_BEZ  = 6'b101000;
  localparam logic [5:0] OP_BNE  = 6'b101001;
  localparam logic [5:0] OP_JMP  = 6'b101010;

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,
    CLS_LD  = 3'd1,
    CLS_ST  = 3'd2,
    CLS_BR  = 3'd3,
    CLS_NOP = 3'd4,
    CLS_ILL = 3'd5
  } op_class_e;

endpackage

// File: rtl/mc_opcode_decoder.sv
// Combinational opcode decoder: ALU command, immediate select, branch type
// and instruction class for one opcode.
module mc_opcode_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int EXEC_CMD_W = 4
) (
  input  logic [OPCODE_W-1:0]   i_op,
  output logic [EXEC_CMD_W-1:0] o_exec_command,
  output logic                  o_is_immediate,
  output logic [1:0]            o_branch_type,
  output logic [2:0]            o_class
);

  logic [3:0] w_cmd;

  // Opcode table lookup; anything not listed is illegal
  always_comb begin
    w_cmd          = CMD_ADD;
    o_is_immediate = 1'b0;
    o_branch_type  = BR_NONE;
    o_class        = CLS_ALU;
    case (i_op)
      OPCODE_W'(OP_NOP):  o_class = CLS_NOP;
      OPCODE_W'(OP_ADD):  w_cmd = CMD_ADD;
      OPCODE_W'(OP_SUB):  w_cmd = CMD_SUB;
      OPCODE_W'(OP_AND):  w_cmd = CMD_AND;
      OPCODE_W'(OP_OR):   w_cmd = CMD_OR;
      OPCODE_W'(OP_NOR):  w_cmd = CMD_NOR;
      OPCODE_W'(OP_XOR):  w_cmd = CMD_XOR;
      OPCODE_W'(OP_SLA),
      OPCODE_W'(OP_SLL):  w_cmd = CMD_SLL;
      OPCODE_W'(OP_SRA):  w_cmd = CMD_SRA;
      OPCODE_W'(OP_SRL):  w_cmd = CMD_SRL;
      OPCODE_W'(OP_ADDI): o_is_immediate = 1'b1;
      OPCODE_W'(OP_SUBI): begin
        w_cmd          = CMD_SUB;
        o_is_immediate = 1'b1;
      end
      OPCODE_W'(OP_LD): begin
        o_class        = CLS_LD;
        o_is_immediate = 1'b1;
      end
      OPCODE_W'(OP_ST): begin
        o_class        = CLS_ST;
        o_is_immediate = 1'b1;
      end
      OPCODE_W'(OP_BEZ): begin
        o_class        = CLS_BR;
        o_is_immediate = 1'b1;
        o_branch_type  = BR_BEZ;
      end
      OPCODE_W'(OP_BNE): begin
        o_class        = CLS_BR;
        o_is_immediate = 1'b1;
        o_branch_type  = BR_BNE;
      end
      OPCODE_W'(OP_JMP): begin
        o_class        = CLS_BR;
        o_branch_type  = BR_JMP;
      end
      default: o_class = CLS_ILL;
    endcase
  end

  assign o_exec_command = EXEC_CMD_W'(w_cmd);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// timeout and retired-instruction counter. Option macro: ILLEGAL_OP_TRAP_EN.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int EXEC_CMD_W = 4,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  mem_ready,
  input  logic                  branch_taken,
  output logic [EXEC_CMD_W-1:0] exec_command,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_enable,
  output logic                  is_immediate,
  output logic [1:0]            branch_type,
  output logic                  if_req,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      retired_count,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic                  illegal_op,
`endif
  output logic                  timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e                r_state;
  logic [OPCODE_W-1:0]   r_op_q;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [CNT_W-1:0]      r_retired;
  logic                  r_timeout_err;

  logic [EXEC_CMD_W-1:0] w_cmd;
  logic                  w_imm;
  logic [1:0]            w_br;
  logic [2:0]            w_cls;

  mc_opcode_decoder #(.OPCODE_W(OPCODE_W), .EXEC_CMD_W(EXEC_CMD_W)) u_dec (
    .i_op           (r_op_q),
    .o_exec_command (w_cmd),
    .o_is_immediate (w_imm),
    .o_branch_type  (w_br),
    .o_class        (w_cls)
  );

`ifdef ILLEGAL_OP_TRAP_EN
  logic                  r_illegal_op;
  logic [EXEC_CMD_W-1:0] w_in_cmd;
  logic                  w_in_imm;
  logic [1:0]            w_in_br;
  logic [2:0]            w_in_cls;

  // The live opcode is screened in DECODE, before it reaches op_q
  mc_opcode_decoder #(.OPCODE_W(OPCODE_W), .EXEC_CMD_W(EXEC_CMD_W)) u_dec_in (
    .i_op           (opcode),
    .o_exec_command (w_in_cmd),
    .o_is_immediate (w_in_imm),
    .o_branch_type  (w_in_br),
    .o_class        (w_in_cls)
  );

  assign illegal_op = r_illegal_op;
`endif

  // Sequencer state, wait counter, retire counter and sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_op_q        <= {OPCODE_W{1'b0}};
      r_wait_cnt    <= {WAIT_W{1'b0}};
      r_retired     <= {CNT_W{1'b0}};
      r_timeout_err <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      r_illegal_op  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_state <= S_DECODE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state       <= S_ERROR;
            r_timeout_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          r_op_q <= opcode;
`ifdef ILLEGAL_OP_TRAP_EN
          if (w_in_cls == CLS_ILL) begin
            r_state      <= S_ERROR;
            r_illegal_op <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
`else
          r_state <= S_EXEC;
`endif
        end
        S_EXEC: begin
          case (w_cls)
            CLS_ALU: r_state <= S_WB;
            CLS_LD, CLS_ST: begin
              r_state    <= S_MEM;
              r_wait_cnt <= {WAIT_W{1'b0}};
            end
            default: begin
              r_state    <= S_FETCH;
              r_wait_cnt <= {WAIT_W{1'b0}};
              r_retired  <= r_retired + CNT_W'(1);
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (w_cls == CLS_LD) begin
              r_state <= S_WB;
            end else begin
              r_state    <= S_FETCH;
              r_wait_cnt <= {WAIT_W{1'b0}};
              r_retired  <= r_retired + CNT_W'(1);
            end
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state       <= S_ERROR;
            r_timeout_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          r_state    <= S_FETCH;
          r_wait_cnt <= {WAIT_W{1'b0}};
          r_retired  <= r_retired + CNT_W'(1);
        end
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_ERROR;
      endcase
    end
  end

  // Strobes follow state/op_q; only the handshakes see live inputs
  always_comb begin
    if_req       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    wb_enable    = 1'b0;
    exec_command = {EXEC_CMD_W{1'b0}};
    is_immediate = 1'b0;
    branch_type  = BR_NONE;
    case (r_state)
      S_FETCH: begin
        if_req   = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        exec_command = w_cmd;
        is_immediate = w_imm;
        branch_type  = w_br;
        pc_write     = (w_br == BR_JMP) || ((w_br != BR_NONE) && branch_taken);
      end
      S_MEM: begin
        exec_command = w_cmd;
        is_immediate = w_imm;
        mem_read     = (w_cls == CLS_LD);
        mem_write    = (w_cls == CLS_ST);
      end
      S_WB: begin
        exec_command = w_cmd;
        is_immediate = w_imm;
        wb_enable    = 1'b1;
      end
      default: begin
        if_req = 1'b0;
      end
    endcase
  end

  assign state         = r_state;
  assign retired_count = r_retired;
  assign timeout_err   = r_timeout_err;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Parametrised multicycle successor to the single-cycle control unit. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the existing control signals (exec_command, mem_read, mem_write, wb_enable, is_immediate, branch_type) and adds IR/PC write strobes, a memory-ready handshake with timeout, and a retired-instruction counter. It sits between the instruction register/memory interface and the datapath.

Parameters:
OPCODE_W, 6, opcode width
EXEC_CMD_W, 4, ALU command width
CNT_W, 16, retired-instruction counter width
TIMEOUT, 16, max cycles waiting for mem_ready before error (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
opcode  in  OPCODE_W  IR opcode field, valid from the cycle after ir_write
mem_ready  in  1  instruction/data memory access complete
branch_taken  in  1  branch condition from datapath, valid in EXEC
exec_command  out  EXEC_CMD_W  ALU operation
mem_read  out  1  data-memory read request
mem_write  out  1  data-memory write request
wb_enable  out  1  register-file write strobe
is_immediate  out  1  ALU operand B is immediate
branch_type  out  2  00 none, 01 BEZ, 10 BNE, 11 JMP
if_req  out  1  instruction-fetch request
ir_write  out  1  load IR
pc_write  out  1  load PC
state  out  3  current state, for debug
retired_count  out  CNT_W  completed instructions
timeout_err  out  1  sticky memory timeout

Behaviour:
- Async reset: state=FETCH; wait counter, retired_count and op_q cleared; timeout_err=0. All strobes are combinational from state/op_q and read 0, except if_req=1 (FETCH).
- FETCH: if_req=1. On mem_ready: ir_write=1 and pc_write=1 (PC+1) in the same cycle; next state is DECODE.
- DECODE: op_q <= opcode; all strobes 0; next state is EXEC.
- EXEC: exec_command, is_immediate and branch_type decoded from op_q.
  - Branch/JMP: pc_write=1 if JMP, or if BEZ/BNE with branch_taken; then FETCH.
  - NOP/illegal: FETCH.
  - LD/ST: MEM.
  - ALU ops: WB.
- MEM: mem_read (LD) or mem_write (ST) held until mem_ready. On mem_ready, LD goes to WB and ST goes to FETCH.
- WB: wb_enable=1 for exactly one cycle; then FETCH.
- retired_count increments on every transition into FETCH from EXEC, MEM or WB. It wraps modulo 2^CNT_W.
- Wait counter:
  - Clears on entering FETCH or MEM and increments each cycle without mem_ready.
  - If it reaches TIMEOUT-1 and mem_ready is still 0, next state is ERROR and timeout_err=1.
  - mem_ready on that same cycle wins, and no error is raised.
- ERROR: all strobes 0. The FSM stays there until rst.
- Minimum latencies (cycles), with mem_ready immediate: ALU 4, LD 5, ST 4, branch/NOP 3.
- exec_command/is_immediate hold their EXEC values through MEM and WB. Outside EXEC/MEM/WB they read 0.
- Opcode map (mem = 10 01 00 encoding, as today):
  - 000000 NOP; 000001 ADD; 000011 SUB; 000101 AND; 000110 OR; 000111 NOR; 001000 XOR
  - 001001 SLA; 001010 SLL; 001011 SRA; 001100 SRL
  - 100000 ADDI; 100001 SUBI; 100100 LD; 100101 ST
  - 101000 BEZ; 101001 BNE; 101010 JMP
- exec_command encodings:
  - ADD/ADDI/LD/ST 0000; SUB/SUBI 0010; AND 0100; OR 0101; NOR 0110; XOR 0111
  - SLA/SLL 1000; SRA 1001; SRL 1010
- is_immediate=1 for ADDI, SUBI, LD, ST, BEZ, BNE.
- Any other opcode is illegal.

Optional Feature:
ILLEGAL_OP_TRAP_EN
- Defined: an illegal opcode in DECODE sends the FSM to ERROR, and an extra output illegal_op (1 bit, sticky until rst) is asserted.
- Undefined: an illegal opcode executes as NOP (3 cycles, counted as retired), and the illegal_op port does not exist.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode localparams
  - exec_command encodings
  - branch_type encodings
  - state enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=7
- Sub-module mc_opcode_decoder: combinational, op_q in; exec_command, is_immediate, branch_type, class (ALU/LD/ST/BR/NOP/ILL) out.

Test Plan:
- Reset mid-MEM of an LD -> state=0 immediately (async), retired_count=0, mem_read=0, if_req=1.
- opcode 100000 (ADDI), mem_ready tied 1 -> states 0,1,2,4,0; exec_command=0000, is_immediate=1, wb_enable high one cycle; retired_count 0->1.
- opcode 100100 (LD), mem_ready delayed 3 cycles in MEM -> mem_read high 4 cycles; then WB; total 8 cycles; retired_count +1.
- opcode 101000 (BEZ): branch_taken=1 -> pc_write in EXEC, branch_type=01; repeat with branch_taken=0 -> no EXEC pc_write.
- TIMEOUT=4, mem_ready=0 in FETCH -> ERROR after 4 cycles, timeout_err=1, stays until rst; with mem_ready on 4th cycle -> DECODE, no error.
- opcode 111111 -> without ILLEGAL_OP_TRAP_EN: NOP, retired_count +1; with it: ERROR, illegal_op=1.
